// File: rtl/vx_cache_wb_drain.sv
// Write-back drain queue for one cache bank: buffers evicted dirty lines, coalesces
// repeat evictions of queued lines, and issues them in order as byte-masked writes.
module vx_cache_wb_drain #(
    parameter int LINE_SIZE  = 16,
    parameter int ADDR_WIDTH = 26,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         evict_valid,
    input  logic [ADDR_WIDTH-1:0]        evict_addr,
    input  logic [LINE_SIZE*8-1:0]       evict_data,
    input  logic [LINE_SIZE-1:0]         evict_byteen,
    output logic                         evict_ready,
    output logic                         mem_req_valid,
    output logic                         mem_req_rw,
    output logic [ADDR_WIDTH-1:0]        mem_req_addr,
    output logic [LINE_SIZE*8-1:0]       mem_req_data,
    output logic [LINE_SIZE-1:0]         mem_req_byteen,
    output logic [TAG_WIDTH-1:0]         mem_req_tag,
    input  logic                         mem_req_ready,
    input  logic [ADDR_WIDTH-1:0]        lookup_addr,
    output logic                         lookup_hit,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int DATA_W = LINE_SIZE * 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      valid_q;
    logic [ADDR_WIDTH-1:0] addr_q   [DEPTH];
    logic [DATA_W-1:0]     data_q   [DEPTH];
    logic [LINE_SIZE-1:0]  byteen_q [DEPTH];
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      count_q;
    logic [TAG_WIDTH-1:0]  tag_q;

    logic [DEPTH-1:0] merge_sel;
    logic             merge_hit, dirty, full;
    logic             do_merge, do_enq, do_deq;

    // The head may already be on the memory bus, so it is never a merge target.
    always_comb begin
        merge_sel  = '0;
        lookup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            merge_sel[i] = valid_q[i] && (PTR_W'(i) != head_q) && (addr_q[i] == evict_addr);
            if (valid_q[i] && (addr_q[i] == lookup_addr))
                lookup_hit = 1'b1;
        end
        merge_hit   = |merge_sel;
        dirty       = |evict_byteen;
        full        = (count_q == CNT_W'(DEPTH));
        evict_ready = !reset && (!dirty || merge_hit || !full);
        do_merge    = evict_valid && evict_ready && dirty && merge_hit;
        do_enq      = evict_valid && evict_ready && dirty && !merge_hit;
        do_deq      = mem_req_valid && mem_req_ready;
    end

    assign mem_req_valid  = (count_q != '0);
    assign mem_req_rw     = 1'b1;
    assign mem_req_addr   = addr_q[head_q];
    assign mem_req_data   = data_q[head_q];
    assign mem_req_byteen = byteen_q[head_q];
    assign mem_req_tag    = tag_q;
    assign count          = count_q;
    assign empty          = (count_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            tag_q   <= '0;
        end else begin
            if (do_deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
                tag_q           <= tag_q + TAG_WIDTH'(1);
            end
            if (do_enq) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; valid_q alone decides what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_merge && merge_sel[i]) begin
                for (int b = 0; b < LINE_SIZE; b++)
                    if (evict_byteen[b])
                        data_q[i][b*8 +: 8] <= evict_data[b*8 +: 8];
                byteen_q[i] <= byteen_q[i] | evict_byteen;
            end else if (do_enq && (PTR_W'(i) == tail_q)) begin
                addr_q[i]   <= evict_addr;
                data_q[i]   <= evict_data;
                byteen_q[i] <= evict_byteen;
            end
        end
    end

endmodule
